// File: rtl/vp_update_sched.sv
// Serialises per-lane predictor feedback and full-table flush sweeps onto one table write port.
// Latency: feedback to upd_valid_o in 1 cycle. Backpressure: upd_* holds while !upd_ready_i, lanes stall when FIFO full.
// Optional statistics counters are enabled by defining VP_UPD_STATS_EN.
module vp_update_sched #(
    parameter int  P_NUM_PRED     = 2,
    parameter int  P_STORAGE_SIZE = 2048,
    parameter int  P_FIFO_DEPTH   = 4,
    localparam int P_INDEX_WIDTH  = $clog2(P_STORAGE_SIZE)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [P_NUM_PRED-1:0]        fb_valid_i,
    input  logic [P_NUM_PRED-1:0][31:0]  fb_pc_i,
    input  logic [P_NUM_PRED-1:0][31:0]  fb_actual_i,
    output logic [P_NUM_PRED-1:0]        fb_ready_o,
    input  logic                         flush_i,
    output logic                         flush_busy_o,
    output logic                         upd_valid_o,
    output logic [P_INDEX_WIDTH-1:0]     upd_index_o,
    output logic [31:0]                  upd_value_o,
    output logic                         upd_clear_o,
    input  logic                         upd_ready_i,
    output logic [31:0]                  upd_cnt_o,
    output logic [31:0]                  stall_cnt_o
);
    localparam int LP_PW = $clog2(P_FIFO_DEPTH);
    localparam int LP_LW = (P_NUM_PRED > 1) ? $clog2(P_NUM_PRED) : 1;

    typedef enum logic {S_IDLE, S_FLUSH} state_t;
    typedef struct packed {
        logic [P_INDEX_WIDTH-1:0] idx;
        logic [31:0]              val;
    } ent_t;

    state_t                   r_state;
    logic [P_INDEX_WIDTH-1:0] r_sidx;
    logic [LP_LW-1:0]         r_rr;
    ent_t                     r_mem  [P_NUM_PRED][P_FIFO_DEPTH];
    logic [LP_PW-1:0]         r_wptr [P_NUM_PRED];
    logic [LP_PW-1:0]         r_rptr [P_NUM_PRED];
    logic [LP_PW:0]           r_cnt  [P_NUM_PRED];

    logic                     r_upd_vld;
    logic [P_INDEX_WIDTH-1:0] r_upd_idx;
    logic [31:0]              r_upd_val;
    logic                     r_upd_clr;

    logic                     w_load;
    logic                     w_flush_go;
    logic                     w_gnt_vld;
    logic [LP_LW-1:0]         w_gnt;
    logic [LP_LW-1:0]         w_rr_nxt;
    logic                     w_pop;
    logic [P_NUM_PRED-1:0]    w_empty;
    logic [P_NUM_PRED-1:0]    w_pop_v;
    logic [P_NUM_PRED-1:0]    w_push_v;
    logic [P_NUM_PRED-1:0]    w_unused_pc;
    ent_t                     w_gnt_ent;

    assign w_load     = !r_upd_vld || upd_ready_i;
    assign w_flush_go = (r_state == S_IDLE) && flush_i;
    // FIFOs are never drained on the flush edge so queued entries cannot leak past it.
    assign w_pop      = (r_state == S_IDLE) && !flush_i && w_load && w_gnt_vld;
    assign w_push_v   = fb_valid_i & fb_ready_o;
    assign w_gnt_ent  = r_mem[w_gnt][r_rptr[w_gnt]];
    assign w_rr_nxt   = (w_gnt == LP_LW'(P_NUM_PRED - 1)) ? '0 : w_gnt + 1'b1;

    always_comb begin
        w_empty    = '0;
        fb_ready_o = '0;
        for (int i = 0; i < P_NUM_PRED; i++) begin
            w_empty[i]    = (r_cnt[i] == '0);
            fb_ready_o[i] = (r_state == S_IDLE) && (r_cnt[i] != (LP_PW+1)'(P_FIFO_DEPTH));
        end
    end

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int k = 0; k < P_NUM_PRED; k++) begin
            if (!w_gnt_vld && !w_empty[LP_LW'((int'(r_rr) + k) % P_NUM_PRED)]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = LP_LW'((int'(r_rr) + k) % P_NUM_PRED);
            end
        end
    end

    always_comb begin
        w_pop_v = '0;
        if (w_pop) w_pop_v[w_gnt] = 1'b1;
    end

    genvar g;
    for (g = 0; g < P_NUM_PRED; g++) begin : g_lane
        assign w_unused_pc[g] = ^fb_pc_i[g][31:P_INDEX_WIDTH];

        always_ff @(posedge clk_i) begin
            if (w_push_v[g]) r_mem[g][r_wptr[g]] <= '{idx: fb_pc_i[g][P_INDEX_WIDTH-1:0], val: fb_actual_i[g]};
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_wptr[g] <= '0;
                r_rptr[g] <= '0;
                r_cnt[g]  <= '0;
            end else if (w_flush_go) begin
                r_wptr[g] <= '0;
                r_rptr[g] <= '0;
                r_cnt[g]  <= '0;
            end else begin
                if (w_push_v[g]) r_wptr[g] <= r_wptr[g] + 1'b1;
                if (w_pop_v[g])  r_rptr[g] <= r_rptr[g] + 1'b1;
                case ({w_push_v[g], w_pop_v[g]})
                    2'b10:   r_cnt[g] <= r_cnt[g] + 1'b1;
                    2'b01:   r_cnt[g] <= r_cnt[g] - 1'b1;
                    default: r_cnt[g] <= r_cnt[g];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_sidx    <= '0;
            r_rr      <= '0;
            r_upd_vld <= 1'b0;
            r_upd_idx <= '0;
            r_upd_val <= '0;
            r_upd_clr <= 1'b0;
        end else begin
            if (w_pop) r_rr <= w_rr_nxt;
            case (r_state)
                S_IDLE: begin
                    if (flush_i) begin
                        r_state <= S_FLUSH;
                        r_sidx  <= '0;
                    end
                    if (w_load) begin
                        r_upd_vld <= w_pop;
                        r_upd_clr <= 1'b0;
                        if (w_pop) begin
                            r_upd_idx <= w_gnt_ent.idx;
                            r_upd_val <= w_gnt_ent.val;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_load) begin
                        r_upd_vld <= 1'b1;
                        r_upd_idx <= r_sidx;
                        r_upd_val <= '0;
                        r_upd_clr <= 1'b1;
                        r_sidx    <= r_sidx + 1'b1;
                        if (r_sidx == P_INDEX_WIDTH'(P_STORAGE_SIZE - 1)) r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign flush_busy_o = (r_state == S_FLUSH);
    assign upd_valid_o  = r_upd_vld;
    assign upd_index_o  = r_upd_idx;
    assign upd_value_o  = r_upd_val;
    assign upd_clear_o  = r_upd_clr;

`ifdef VP_UPD_STATS_EN
    logic [31:0] r_upd_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_upd_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_upd_vld && upd_ready_i)  r_upd_cnt   <= r_upd_cnt + 32'd1;
            if (r_upd_vld && !upd_ready_i) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign upd_cnt_o   = r_upd_cnt;
    assign stall_cnt_o = r_stall_cnt;
`else
    assign upd_cnt_o   = '0;
    assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_vp_update_sched.sv
// Scoreboard bench for vp_update_sched: per-lane expected queues, presentation-time monitor, sweep tracking.
module tb_vp_update_sched;
    localparam int NP = 2;
    localparam int SS = 2048;
    localparam int FD = 4;
    localparam int IW = 11;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NP-1:0]        fb_valid_i;
    logic [NP-1:0][31:0]  fb_pc_i;
    logic [NP-1:0][31:0]  fb_actual_i;
    logic [NP-1:0]        fb_ready_o;
    logic                 flush_i;
    logic                 flush_busy_o;
    logic                 upd_valid_o;
    logic [IW-1:0]        upd_index_o;
    logic [31:0]          upd_value_o;
    logic                 upd_clear_o;
    logic                 upd_ready_i;
    logic [31:0]          upd_cnt_o;
    logic [31:0]          stall_cnt_o;

    vp_update_sched #(.P_NUM_PRED(NP), .P_STORAGE_SIZE(SS), .P_FIFO_DEPTH(FD)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .fb_valid_i(fb_valid_i), .fb_pc_i(fb_pc_i), .fb_actual_i(fb_actual_i), .fb_ready_o(fb_ready_o),
        .flush_i(flush_i), .flush_busy_o(flush_busy_o),
        .upd_valid_o(upd_valid_o), .upd_index_o(upd_index_o), .upd_value_o(upd_value_o),
        .upd_clear_o(upd_clear_o), .upd_ready_i(upd_ready_i),
        .upd_cnt_o(upd_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [31:0]   val;
    } item_t;

    item_t             q0[$];
    item_t             q1[$];
    int                order_q[$];
    int                n_chk = 0;
    int                n_fail = 0;
    int                exp_clr = 0;
    int                n_store = 0;
    int                n_stall = 0;
    int                n_xfer = 0;
    bit                mon_seen = 1'b0;
    logic [IW+32:0]    snap;
    logic [1:0]        acc;
    int                viol;
    int                s0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Each new output command is checked once when first presented, then must hold until it transfers.
    initial forever begin
        logic [IW+32:0] cur;
        item_t          it;
        @(negedge clk_i);
        if (!rst_ni) begin
            mon_seen = 1'b0;
        end else if (upd_valid_o) begin
            cur = {upd_clear_o, upd_index_o, upd_value_o};
            if (!mon_seen) begin
                if (upd_clear_o) begin
                    check("clear_index", 64'(upd_index_o), 64'(exp_clr));
                    check("clear_value", 64'(upd_value_o), 64'd0);
                    exp_clr++;
                end else begin
                    n_chk++;
                    n_store++;
                    it = {upd_index_o, upd_value_o};
                    if (q0.size() > 0 && q0[0] == it) begin
                        void'(q0.pop_front());
                        order_q.push_back(0);
                    end else if (q1.size() > 0 && q1[0] == it) begin
                        void'(q1.pop_front());
                        order_q.push_back(1);
                    end else begin
                        n_fail++;
                        $display("FAIL store_match: got idx=%0h val=%0h, expected head of a lane queue", upd_index_o, upd_value_o);
                    end
                end
                snap     = cur;
                mon_seen = 1'b1;
            end else begin
                check("stall_stable", 64'(cur), 64'(snap));
            end
            if (upd_ready_i) begin
                mon_seen = 1'b0;
                n_xfer++;
            end else begin
                n_stall++;
            end
        end
    end

    task automatic offer(input int l, input logic [31:0] pc, input logic [31:0] val);
        fb_valid_i[l]  = 1'b1;
        fb_pc_i[l]     = pc;
        fb_actual_i[l] = val;
    endtask

    // Called just after a rising edge; returns the lanes whose handshake completed on the next edge.
    task automatic cycle(input bit flush, output logic [1:0] a);
        bit taken;
        flush_i = flush;
        @(negedge clk_i);
        #1;
        a     = fb_valid_i & fb_ready_o;
        taken = flush && !flush_busy_o;
        if (!taken) begin
            if (a[0]) q0.push_back({fb_pc_i[0][IW-1:0], fb_actual_i[0]});
            if (a[1]) q1.push_back({fb_pc_i[1][IW-1:0], fb_actual_i[1]});
        end
        @(posedge clk_i);
        #1;
        flush_i    = 1'b0;
        fb_valid_i = fb_valid_i & ~a;
        if (taken) begin
            q0.delete();
            q1.delete();
            exp_clr = 0;
        end
    endtask

    task automatic idle(input int n);
        logic [1:0] a;
        repeat (n) cycle(1'b0, a);
    endtask

    task automatic wait_flush(input string name, output int v);
        bit         done = 1'b0;
        logic [1:0] a;
        v = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            cycle(1'b0, a);
            if (!flush_busy_o) begin
                done = 1'b1;
                check({name, "_busy_fall_idx"}, 64'(exp_clr), 64'(SS - 1));
            end else if (fb_ready_o != 2'b00) begin
                v++;
            end
        end
        check({name, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic check_stats(input string name);
`ifdef VP_UPD_STATS_EN
        check({name, "_stall_cnt"}, 64'(stall_cnt_o), 64'(n_stall));
        check({name, "_upd_cnt"}, 64'(upd_cnt_o), 64'(n_xfer));
`else
        check({name, "_stall_cnt"}, 64'(stall_cnt_o), 64'd0);
        check({name, "_upd_cnt"}, 64'(upd_cnt_o), 64'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni      = 1'b0;
        fb_valid_i  = '0;
        fb_pc_i     = '0;
        fb_actual_i = '0;
        flush_i     = 1'b0;
        upd_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", 64'(upd_valid_o), 64'd0);
        check("rst_index", 64'(upd_index_o), 64'd0);
        check("rst_value", 64'(upd_value_o), 64'd0);
        check("rst_clear", 64'(upd_clear_o), 64'd0);
        check("rst_busy", 64'(flush_busy_o), 64'd0);
        check("rst_upd_cnt", 64'(upd_cnt_o), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
        rst_ni = 1'b1;
        #1;
        check("rst_fb_ready", 64'(fb_ready_o), 64'b11);

        // Fairness from the reset pointer
        upd_ready_i = 1'b1;
        order_q.delete();
        for (int i = 0; i < 4; i++) begin
            offer(0, $urandom, $urandom);
            offer(1, $urandom, $urandom);
            cycle(1'b0, acc);
            check("fair_accept", 64'(acc), 64'b11);
        end
        idle(10);
        check("fair_count", 64'(order_q.size()), 64'd8);
        for (int i = 0; i < order_q.size() && i < 8; i++) check("fair_lane", 64'(order_q[i]), 64'(i % 2));

        // Single lane latency and index extraction
        offer(0, 32'h0000_1804, 32'hDEAD_BEEF);
        cycle(1'b0, acc);
        check("single_accept", 64'(acc), 64'b01);
        check("single_valid_early", 64'(upd_valid_o), 64'd0);
        cycle(1'b0, acc);
        check("single_valid", 64'(upd_valid_o), 64'd1);
        check("single_index", 64'(upd_index_o), 64'h004);
        check("single_value", 64'(upd_value_o), 64'hDEAD_BEEF);
        check("single_clear", 64'(upd_clear_o), 64'd0);
        idle(3);

        // Back-pressure: 4 in the FIFO plus 1 held in the output stage
        upd_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(0, $urandom, $urandom);
            cycle(1'b0, acc);
            check("bp_accept", 64'(acc[0]), 64'd1);
        end
        check("bp_fb_ready", 64'(fb_ready_o), 64'b10);
        idle(6);
        check("bp_fb_ready_hold", 64'(fb_ready_o), 64'b10);
        check_stats("bp");
        upd_ready_i = 1'b1;
        idle(8);
        check("bp_drain_ready", 64'(fb_ready_o), 64'b11);
        check("bp_drain_q0", 64'(q0.size()), 64'd0);

        // Flush with one command held and three queued
        upd_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(0, $urandom, $urandom);
            cycle(1'b0, acc);
        end
        check("fl_queued", 64'(q0.size()), 64'd3);
        s0 = n_store;
        cycle(1'b1, acc);
        check("fl_busy", 64'(flush_busy_o), 64'd1);
        check("fl_fb_ready", 64'(fb_ready_o), 64'b00);
        idle(3);
        upd_ready_i = 1'b1;
        wait_flush("fl", viol);
        check("fl_ready_low", 64'(viol), 64'd0);
        idle(3);
        check("fl_clear_count", 64'(exp_clr), 64'(SS));
        check("fl_no_stale_store", 64'(n_store - s0), 64'd0);
        check("fl_ready_back", 64'(fb_ready_o), 64'b11);

        // Feedback on the flush edge is discarded
        s0 = n_store;
        offer(0, 32'h0000_0ABC, 32'h1234_5678);
        cycle(1'b1, acc);
        check("sim_accept", 64'(acc[0]), 64'd1);
        wait_flush("sim", viol);
        idle(3);
        check("sim_no_store", 64'(n_store - s0), 64'd0);
        check("sim_clear_count", 64'(exp_clr), 64'(SS));
        check_stats("sim");

        // Reset mid-sweep
        cycle(1'b1, acc);
        for (int k = 0; k < 500 && exp_clr < 100; k++) cycle(1'b0, acc);
        check("rm_reached_100", 64'(exp_clr >= 100), 64'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("rm_valid", 64'(upd_valid_o), 64'd0);
        check("rm_index", 64'(upd_index_o), 64'd0);
        check("rm_value", 64'(upd_value_o), 64'd0);
        check("rm_clear", 64'(upd_clear_o), 64'd0);
        check("rm_busy", 64'(flush_busy_o), 64'd0);
        check("rm_upd_cnt", 64'(upd_cnt_o), 64'd0);
        check("rm_stall_cnt", 64'(stall_cnt_o), 64'd0);
        q0.delete();
        q1.delete();
        exp_clr = 0;
        n_stall = 0;
        n_xfer  = 0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
        check("rm_busy_after", 64'(flush_busy_o), 64'd0);
        check("rm_fb_ready_after", 64'(fb_ready_o), 64'b11);

        // Random traffic with random back-pressure
        for (int c = 0; c < 600; c++) begin
            for (int l = 0; l < NP; l++) begin
                if (!fb_valid_i[l] && $urandom_range(1, 0) == 1) offer(l, $urandom, $urandom);
            end
            upd_ready_i = ($urandom_range(3, 0) != 0);
            cycle(1'b0, acc);
        end
        upd_ready_i = 1'b1;
        idle(20);
        check("rnd_q0_empty", 64'(q0.size()), 64'd0);
        check("rnd_q1_empty", 64'(q1.size()), 64'd0);
        check("rnd_fb_ready", 64'(fb_ready_o), 64'b11);
        check_stats("rnd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
